cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have ports clk (input, 1, rising-edge clock) and rst (input, 1, reset), with one clock and an asynchronous, active-high reset.
REQ-002 SHALL have i_pmem_read (input, 1): I-cache line-fill request.
REQ-003 SHALL have i_pmem_address (input, 16, lc3b_word): I-cache line address.
REQ-004 SHALL have i_pmem_rdata (output, 128, lc3b_line): line data to the I-cache.
REQ-005 SHALL have i_pmem_resp (output, 1): I-cache transfer done.
REQ-006 SHALL have d_pmem_read and d_pmem_write (inputs, 1 each): D-cache fill and writeback requests.
REQ-007 SHALL have d_pmem_address (input, 16) and d_pmem_wdata (input, 128): D-cache address and writeback line.
REQ-008 SHALL have d_pmem_rdata (output, 128) and d_pmem_resp (output, 1): D-cache data and completion.
REQ-009 SHALL have pmem_read and pmem_write (outputs, 1 each): commands to physical memory.
REQ-010 SHALL have pmem_address (output, 16) and pmem_wdata (output, 128): address and write line to physical memory.
REQ-011 SHALL have pmem_rdata (input, 128) and pmem_resp (input, 1): data and completion from physical memory.

Function
REQ-012 SHALL implement the FSM states IDLE, SERVE_I and SERVE_D.
REQ-013 In IDLE, SHALL grant on any request; with exactly one requester pending, that requester wins.
REQ-014 In IDLE with both requesters pending, SHALL grant the requester not granted last (round-robin flop last_grant, reset value I, so the first contest goes to D).
REQ-015 On a grant, SHALL latch the address, wdata and operation into command registers; the D operation is write if d_pmem_write=1, else read, so write wins if both are asserted (illegal input).
REQ-016 Latency: request sampled in IDLE at edge N SHALL produce pmem_read or pmem_write asserted from registers in the cycle after N, held stable until pmem_resp.
REQ-017 A granted requester that drops its request mid-transfer SHALL NOT abort the transfer; the latched command is held until pmem_resp.
REQ-018 SHALL route pmem_resp combinationally to the granted client's resp only, in the same cycle, and never to both.
REQ-019 SHALL drive i_pmem_rdata and d_pmem_rdata = pmem_rdata continuously (broadcast); the rdata value is meaningful only with the matching resp.
REQ-020 On pmem_resp, SHALL enter IDLE at the next edge with pmem_read=pmem_write=0 for at least one cycle (bubble); the next grant is evaluated in IDLE.
REQ-021 pmem_resp while in IDLE SHALL be ignored: no client resp.
REQ-022 SHALL update last_grant on each grant.
REQ-023 Back-to-back requests from the same client with the other idle SHALL each be granted, with one IDLE bubble between them.

Reset
REQ-024 While rst=1, SHALL hold the FSM in IDLE, last_grant=I, command registers=0, and pmem_read, pmem_write, i_pmem_resp and d_pmem_resp=0, taking effect immediately without waiting for clk.
REQ-025 Reset mid-transfer SHALL abandon the transfer; the first grant after rst deasserts follows REQ-013 and REQ-014.

Structure
REQ-026 lc3b_word and lc3b_line (128-bit) SHALL come from the shared lc3b_types package.
REQ-027 The arbiter state enum and grant_t (I/D) SHALL be declared in lc3b_types.
REQ-028 SHALL be a single module with no sub-modules; FSM, command registers and response steering are local.

Verification
REQ-029 Only I requests, addr 0x1230, with memory resp after 3 cycles -> pmem_read=1 with pmem_address=0x1230 in cycle 1; i_pmem_resp pulses 1 cycle with pmem_rdata; d_pmem_resp stays 0.
REQ-030 D write at addr 0x4440 with wdata 0xDEAD...BEEF -> pmem_write=1 with matching address and wdata; only d_pmem_resp pulses; pmem_read=0 throughout.
REQ-031 I and D request in the same cycle after reset -> D is served first; then IDLE bubble; then I is served at its own address; next simultaneous contest goes to D again (alternation).
REQ-032 I drops i_pmem_read 1 cycle after grant while D requests -> pmem_address stays the I address until pmem_resp; D is granted only after the bubble.
REQ-033 rst asserted mid SERVE_D -> pmem_write=0 in the same cycle without a clock edge; after release, a pending I request is granted next cycle.
REQ-034 Spurious pmem_resp in IDLE -> neither client resp asserts and the state is unchanged.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: memory word/line widths plus the arbiter's state and grant encodings.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache with round-robin
// arbitration; each granted command is latched and held until memory responds.
module cache_arbiter
   import lc3b_types::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     i_pmem_read,
   input  lc3b_word i_pmem_address,
   output lc3b_line i_pmem_rdata,
   output logic     i_pmem_resp,
   input  logic     d_pmem_read,
   input  logic     d_pmem_write,
   input  lc3b_word d_pmem_address,
   input  lc3b_line d_pmem_wdata,
   output lc3b_line d_pmem_rdata,
   output logic     d_pmem_resp,
   output logic     pmem_read,
   output logic     pmem_write,
   output lc3b_word pmem_address,
   output lc3b_line pmem_wdata,
   input  lc3b_line pmem_rdata,
   input  logic     pmem_resp
);

   arb_state_t r_state;
   grant_t     r_last_grant;
   lc3b_word   r_addr;
   lc3b_line   r_wdata;
   logic       r_read;
   logic       r_write;

   logic       w_req_i;
   logic       w_req_d;
   grant_t     w_grant;

   // On a tie the client that did not win last time gets the port.
   always_comb begin
      w_req_i = i_pmem_read;
      w_req_d = d_pmem_read | d_pmem_write;
      w_grant = GRANT_I;
      if (w_req_d && (!w_req_i || r_last_grant == GRANT_I))
         w_grant = GRANT_D;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_grant <= GRANT_I;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_read       <= 1'b0;
         r_write      <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_req_i || w_req_d) begin
                  r_last_grant <= w_grant;
                  if (w_grant == GRANT_D) begin
                     r_state <= SERVE_D;
                     r_addr  <= d_pmem_address;
                     r_wdata <= d_pmem_wdata;
                     // A simultaneous read+write from D is treated as a write.
                     r_write <= d_pmem_write;
                     r_read  <= ~d_pmem_write;
                  end else begin
                     r_state <= SERVE_I;
                     r_addr  <= i_pmem_address;
                     r_read  <= 1'b1;
                     r_write <= 1'b0;
                  end
               end
            end
            SERVE_I, SERVE_D: begin
               if (pmem_resp) begin
                  r_state <= IDLE;
                  r_read  <= 1'b0;
                  r_write <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_read  <= 1'b0;
               r_write <= 1'b0;
            end
         endcase
      end
   end

   assign pmem_read    = r_read;
   assign pmem_write   = r_write;
   assign pmem_address = r_addr;
   assign pmem_wdata   = r_wdata;

   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;
   assign i_pmem_resp  = pmem_resp && (r_state == SERVE_I);
   assign d_pmem_resp  = pmem_resp && (r_state == SERVE_D);

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a transaction-level ownership model checked every
// falling edge, plus literal expectations at the key points of each scenario.
module tb_cache_arbiter;
   import lc3b_types::*;

   logic     clk = 1'b0;
   logic     rst;
   logic     i_pmem_read;
   lc3b_word i_pmem_address;
   lc3b_line i_pmem_rdata;
   logic     i_pmem_resp;
   logic     d_pmem_read;
   logic     d_pmem_write;
   lc3b_word d_pmem_address;
   lc3b_line d_pmem_wdata;
   lc3b_line d_pmem_rdata;
   logic     d_pmem_resp;
   logic     pmem_read;
   logic     pmem_write;
   lc3b_word pmem_address;
   lc3b_line pmem_wdata;
   lc3b_line pmem_rdata;
   logic     pmem_resp;

   int n_total = 0;
   int n_pass  = 0;

   cache_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_address (i_pmem_address),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_address (d_pmem_address),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_rdata   (d_pmem_rdata),
      .d_pmem_resp    (d_pmem_resp),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: who currently owns memory (0 none, 1 I, 2 D), who won last, and the
   // transaction that owner was granted.
   int       m_owner;
   int       m_last;
   lc3b_word m_addr;
   lc3b_line m_wdata;
   bit       m_is_write;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner    <= 0;
         m_last     <= 1;
         m_addr     <= '0;
         m_wdata    <= '0;
         m_is_write <= 1'b0;
      end else if (m_owner != 0) begin
         if (pmem_resp) m_owner <= 0;
      end else begin
         bit want_i, want_d;
         int winner;
         want_i = i_pmem_read;
         want_d = d_pmem_read || d_pmem_write;
         winner = 0;
         if (want_i && want_d) winner = (m_last == 1) ? 2 : 1;
         else if (want_i)      winner = 1;
         else if (want_d)      winner = 2;
         if (winner == 1) begin
            m_owner <= 1; m_last <= 1; m_addr <= i_pmem_address; m_is_write <= 1'b0;
         end else if (winner == 2) begin
            m_owner <= 2; m_last <= 2; m_addr <= d_pmem_address;
            m_wdata <= d_pmem_wdata; m_is_write <= d_pmem_write;
         end
      end
   end

   always @(negedge clk) begin
      check("mdl_read",   pmem_read,   (m_owner != 0) && !m_is_write);
      check("mdl_write",  pmem_write,  (m_owner != 0) && m_is_write);
      check("mdl_i_resp", i_pmem_resp, pmem_resp && !rst && m_owner == 1);
      check("mdl_d_resp", d_pmem_resp, pmem_resp && !rst && m_owner == 2);
      check("mdl_i_rdata", i_pmem_rdata, pmem_rdata);
      check("mdl_d_rdata", d_pmem_rdata, pmem_rdata);
      if (m_owner != 0) check("mdl_addr", pmem_address, m_addr);
      if (m_owner == 2 && m_is_write) check("mdl_wdata", pmem_wdata, m_wdata);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam lc3b_line WD_A = 128'hDEAD_0001_0002_0003_0004_0005_0006_BEEF;
   localparam lc3b_line WD_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

   initial begin
      rst = 1'b1;
      i_pmem_read = 0; i_pmem_address = '0;
      d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
      pmem_rdata = '0; pmem_resp = 0;
      tick(); tick();
      check("rst_read",  pmem_read,    1'b0);
      check("rst_write", pmem_write,   1'b0);
      check("rst_addr",  pmem_address, 16'h0);
      check("rst_iresp", i_pmem_resp,  1'b0);
      check("rst_dresp", d_pmem_resp,  1'b0);
      rst = 1'b0;
      tick();

      // I-only fill, memory answers after 3 cycles
      i_pmem_read = 1; i_pmem_address = 16'h1230;
      tick();
      check("i_only_read", pmem_read,    1'b1);
      check("i_only_addr", pmem_address, 16'h1230);
      i_pmem_read = 0;
      tick(); tick();
      pmem_rdata = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666; pmem_resp = 1; #1;
      check("i_only_iresp", i_pmem_resp, 1'b1);
      check("i_only_dresp", d_pmem_resp, 1'b0);
      check("i_only_rdata", i_pmem_rdata, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
      tick(); pmem_resp = 0; #1;
      check("i_only_bubble", pmem_read, 1'b0);

      // D writeback
      d_pmem_write = 1; d_pmem_address = 16'h4440; d_pmem_wdata = WD_A;
      tick();
      check("d_wr_write", pmem_write,   1'b1);
      check("d_wr_read",  pmem_read,    1'b0);
      check("d_wr_addr",  pmem_address, 16'h4440);
      check("d_wr_wdata", pmem_wdata,   WD_A);
      d_pmem_write = 0;
      tick(); pmem_resp = 1; #1;
      check("d_wr_dresp", d_pmem_resp, 1'b1);
      check("d_wr_iresp", i_pmem_resp, 1'b0);
      tick(); pmem_resp = 0;

      // Simultaneous contest right after reset goes to D, then alternates
      rst = 1; tick(); rst = 0;
      i_pmem_read = 1; i_pmem_address = 16'h1111;
      d_pmem_read = 1; d_pmem_address = 16'h2222;
      tick();
      check("rr1_addr", pmem_address, 16'h2222);
      check("rr1_read", pmem_read,    1'b1);
      pmem_resp = 1; #1;
      check("rr1_dresp", d_pmem_resp, 1'b1);
      check("rr1_iresp", i_pmem_resp, 1'b0);
      d_pmem_read = 0;
      tick(); pmem_resp = 0; #1;
      check("rr1_bubble", pmem_read, 1'b0);
      tick();
      check("rr1_i_addr", pmem_address, 16'h1111);
      pmem_resp = 1; #1;
      check("rr1_i_iresp", i_pmem_resp, 1'b1);
      tick(); pmem_resp = 0;
      i_pmem_address = 16'h3333;
      d_pmem_read = 1; d_pmem_address = 16'h4444;
      tick();
      check("rr2_addr_d", pmem_address, 16'h4444);
      pmem_resp = 1;
      tick(); pmem_resp = 0;
      tick();
      check("rr3_addr_i", pmem_address, 16'h3333);
      pmem_resp = 1;
      i_pmem_read = 0; d_pmem_read = 0;
      tick(); pmem_resp = 0;

      // I drops its request mid-transfer while D waits
      i_pmem_read = 1; i_pmem_address = 16'h5550;
      tick();
      i_pmem_read = 0; d_pmem_read = 1; d_pmem_address = 16'h6660;
      tick();
      check("drop_hold1", pmem_address, 16'h5550);
      tick();
      check("drop_hold2", pmem_address, 16'h5550);
      check("drop_read",  pmem_read,    1'b1);
      pmem_rdata = WD_B; pmem_resp = 1; #1;
      check("drop_iresp", i_pmem_resp, 1'b1);
      check("drop_dresp", d_pmem_resp, 1'b0);
      tick(); pmem_resp = 0; #1;
      check("drop_bubble", pmem_read, 1'b0);
      tick();
      check("drop_d_addr", pmem_address, 16'h6660);
      pmem_resp = 1; #1;
      check("drop_d_dresp", d_pmem_resp, 1'b1);
      tick(); pmem_resp = 0; d_pmem_read = 0;

      // Asynchronous reset in the middle of a D write
      d_pmem_write = 1; d_pmem_address = 16'h7770; d_pmem_wdata = WD_B;
      tick();
      check("arst_pre_write", pmem_write, 1'b1);
      d_pmem_write = 0; i_pmem_read = 1; i_pmem_address = 16'h8880;
      #2 rst = 1; #1;
      check("arst_write", pmem_write, 1'b0);
      check("arst_dresp", d_pmem_resp, 1'b0);
      tick(); rst = 0;
      tick();
      check("arst_i_read", pmem_read,    1'b1);
      check("arst_i_addr", pmem_address, 16'h8880);
      i_pmem_read = 0; pmem_resp = 1;
      tick(); pmem_resp = 0;

      // Spurious memory response while idle
      tick();
      pmem_resp = 1; #1;
      check("spur_iresp", i_pmem_resp, 1'b0);
      check("spur_dresp", d_pmem_resp, 1'b0);
      tick();
      check("spur_read",  pmem_read,  1'b0);
      check("spur_write", pmem_write, 1'b0);
      pmem_resp = 0;
      i_pmem_read = 1; i_pmem_address = 16'h9990;
      tick();
      check("spur_next_read", pmem_read,    1'b1);
      check("spur_next_addr", pmem_address, 16'h9990);
      i_pmem_read = 0; pmem_resp = 1;
      tick(); pmem_resp = 0;
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
